// File: rtl/hdmi_audio_sample_sched.sv
// HDMI audio sample scheduler: fractional-rate strobe generator,
// stereo sample capture and a small drain FIFO with block-start flags.
module hdmi_audio_sample_sched #(
    parameter int CLK_HZ     = 74250000,
    parameter int SAMPLE_HZ  = 48000,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_LEN  = 192
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    output logic                          sample_ena,
    input  logic signed [15:0]            audio_l,
    input  logic signed [15:0]            audio_r,
    output logic                          pkt_valid,
    input  logic                          pkt_ready,
    output logic signed [15:0]            pkt_left,
    output logic signed [15:0]            pkt_right,
    output logic                          pkt_block_start,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int ACC_W = $clog2(CLK_HZ) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int FRM_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [ACC_W-1:0] STEP  = ACC_W'(SAMPLE_HZ);
    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_HZ);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_LEN - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] nxt;
    logic             capture_pending;
    logic [FRM_W-1:0] frame_cnt;

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [LVL_W-1:0] level;

    logic signed [15:0] mem_l  [FIFO_DEPTH];
    logic signed [15:0] mem_r  [FIFO_DEPTH];
    logic               mem_bs [FIFO_DEPTH];

    logic full;
    logic pop;
    logic push;
    logic drop;

    // acc < CLK_HZ and SAMPLE_HZ < CLK_HZ, so the sum fits in ACC_W bits
    assign nxt = acc + STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc             <= '0;
            sample_ena      <= 1'b0;
            capture_pending <= 1'b0;
        end else if (!enable) begin
            acc             <= '0;
            sample_ena      <= 1'b0;
            capture_pending <= 1'b0;
        end else begin
            capture_pending <= sample_ena;
            if (nxt >= LIMIT) begin
                acc        <= nxt - LIMIT;
                sample_ena <= 1'b1;
            end else begin
                acc        <= nxt;
                sample_ena <= 1'b0;
            end
        end
    end

    // Frame position advances on every capture attempt, dropped or not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (!enable) begin
            frame_cnt <= '0;
        end else if (capture_pending) begin
            frame_cnt <= (frame_cnt == FRM_LAST) ? '0 : frame_cnt + 1'b1;
        end
    end

    assign full      = (level == FULL_LVL);
    assign pkt_valid = (level != '0);
    assign pop       = pkt_valid & pkt_ready;
    assign push      = capture_pending & (~full | pop);
    assign drop      = capture_pending & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_l[i]  <= '0;
                mem_r[i]  <= '0;
                mem_bs[i] <= 1'b0;
            end
        end else if (push) begin
            mem_l[wptr]  <= audio_l;
            mem_r[wptr]  <= audio_r;
            mem_bs[wptr] <= (frame_cnt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign pkt_left        = mem_l[rptr];
    assign pkt_right       = mem_r[rptr];
    assign pkt_block_start = mem_bs[rptr];
    assign fifo_level      = level;

endmodule
